// File: rtl/alert_ping_scheduler_if.sv
// ============================================================================
// Module      : alert_ping_scheduler_if
// Description : Ping handshake bundle between the ping scheduler and the
//               per-channel alert receivers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface alert_ping_scheduler_if #(
    parameter int NALERTS = 4
);
    logic [NALERTS-1:0] ping_req_o;
    logic [NALERTS-1:0] ping_ok_i;
    logic [NALERTS-1:0] ping_timeout_o;

    modport master (
        output ping_req_o,
        output ping_timeout_o,
        input  ping_ok_i
    );

    modport slave (
        input  ping_req_o,
        input  ping_timeout_o,
        output ping_ok_i
    );
endinterface

`default_nettype wire

// File: rtl/alert_ping_scheduler.sv
// ============================================================================
// Module      : alert_ping_scheduler
// Description : Round-robin ping scheduler sharing the receiver ping mechanism
//               across NALERTS channels, with per-channel response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alert_ping_scheduler #(
    parameter int NALERTS    = 4,
    parameter int WAIT_CNT_W = 16,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [WAIT_CNT_W-1:0] wait_cyc_i,
    input  logic [TIMEOUT_W-1:0]  timeout_cyc_i,
    input  logic [NALERTS-1:0]    alert_en_i,
    alert_ping_scheduler_if.master ping_if,
    output logic                  busy_o
);

    localparam int                 c_idx_w    = $clog2(NALERTS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NALERTS - 1);
    localparam logic [NALERTS-1:0] c_one      = NALERTS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PING = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [TIMEOUT_W-1:0]    to_cnt_q, to_cnt_d;
    logic [TIMEOUT_W-1:0]    to_last;
    logic [c_idx_w-1:0]      last_idx_q, last_idx_d;
    logic [c_idx_w-1:0]      sel_q, sel_d;
    logic [c_idx_w-1:0]      srch_idx, cand_idx;
    logic                    srch_found;
    logic [NALERTS-1:0]      ping_req_q, ping_req_d;
    logic [NALERTS-1:0]      ping_timeout_q, ping_timeout_d;
    logic                    busy_q, busy_d;
    int                      cand;

    // Last cycle index of the response window; a zero timeout behaves as one cycle.
    assign to_last = (timeout_cyc_i == '0) ? '0 : timeout_cyc_i - TIMEOUT_W'(1);

    // Walk downwards so the lowest rotation offset after last_idx wins.
    always_comb begin
        srch_found = 1'b0;
        srch_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = NALERTS - 1; k >= 0; k--) begin
            cand     = (int'(last_idx_q) + 1 + k) % NALERTS;
            cand_idx = c_idx_w'(cand);
            if (alert_en_i[cand_idx]) begin
                srch_found = 1'b1;
                srch_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        to_cnt_d       = to_cnt_q;
        last_idx_d     = last_idx_q;
        sel_d          = sel_q;
        ping_req_d     = '0;
        ping_timeout_d = '0;

        if (!en_i) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            to_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = wait_cyc_i;
                end
                ST_WAIT: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                    end else if (srch_found) begin
                        state_d    = ST_PING;
                        sel_d      = srch_idx;
                        last_idx_d = srch_idx;
                        to_cnt_d   = '0;
                        ping_req_d = c_one << srch_idx;
                    end else begin
                        wait_cnt_d = wait_cyc_i;
                    end
                end
                ST_PING: begin
                    // A dropped channel enable or a response both close the ping quietly.
                    if (!alert_en_i[sel_q] || ping_if.ping_ok_i[sel_q]) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = wait_cyc_i;
                        to_cnt_d   = '0;
                    end else if (to_cnt_q >= to_last) begin
                        ping_timeout_d = c_one << sel_q;
                        state_d        = ST_WAIT;
                        wait_cnt_d     = wait_cyc_i;
                        to_cnt_d       = '0;
                    end else begin
                        to_cnt_d   = to_cnt_q + TIMEOUT_W'(1);
                        ping_req_d = c_one << sel_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= '0;
            to_cnt_q       <= '0;
            last_idx_q     <= c_last_idx;
            sel_q          <= '0;
            ping_req_q     <= '0;
            ping_timeout_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            to_cnt_q       <= to_cnt_d;
            last_idx_q     <= last_idx_d;
            sel_q          <= sel_d;
            ping_req_q     <= ping_req_d;
            ping_timeout_q <= ping_timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign ping_if.ping_req_o     = ping_req_q;
    assign ping_if.ping_timeout_o = ping_timeout_q;
    assign busy_o                 = busy_q;

    a_req_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(ping_req_q));

    a_timeout_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(ping_timeout_q) && !((|ping_timeout_q) && (|ping_req_q)));

    a_no_req_after_disable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !en_i |=> (ping_req_q == '0));

endmodule

`default_nettype wire

// File: tb/tb_alert_ping_scheduler.sv
// ============================================================================
// Module      : tb_alert_ping_scheduler
// Description : Self-checking bench for alert_ping_scheduler: directed
//               scenarios plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alert_ping_scheduler;

    localparam int N  = 4;
    localparam int WW = 16;
    localparam int TW = 16;

    logic          clk         = 1'b0;
    logic          rst_ni      = 1'b0;
    logic          en          = 1'b0;
    logic [WW-1:0] wait_cyc    = WW'(3);
    logic [TW-1:0] timeout_cyc = TW'(10);
    logic [N-1:0]  alert_en    = '1;
    logic          busy;

    alert_ping_scheduler_if #(.NALERTS(N)) ping_if ();

    alert_ping_scheduler #(
        .NALERTS    (N),
        .WAIT_CNT_W (WW),
        .TIMEOUT_W  (TW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_i          (en),
        .wait_cyc_i    (wait_cyc),
        .timeout_cyc_i (timeout_cyc),
        .alert_en_i    (alert_en),
        .ping_if       (ping_if.master),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // Model: a ping either is outstanding (with its age in request cycles) or
    // the scheduler is counting down the idle gap before the next rotation pick.
    typedef struct {
        bit           active;
        bit           pinging;
        int           left;
        int           age;
        int           chan;
        int           last;
        logic [N-1:0] req;
        logic [N-1:0] tmo;
        bit           busy;
    } model_t;

    model_t m;

    function automatic bit bit_of(logic [N-1:0] v, int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        return N'(1) << i;
    endfunction

    function automatic int idx_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (bit_of(v, i)) return i;
        return -1;
    endfunction

    function automatic int next_chan(int last, logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) if (bit_of(mask, (last + k) % N)) return (last + k) % N;
        return -1;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.active = 0; r.pinging = 0; r.left = 0; r.age = 0; r.chan = 0;
        r.last = N - 1; r.req = '0; r.tmo = '0; r.busy = 0;
        return r;
    endfunction

    function automatic model_t step(model_t s, logic e, logic [WW-1:0] wc,
                                    logic [TW-1:0] tc, logic [N-1:0] ae, logic [N-1:0] ok);
        model_t n;
        int     t;
        int     c;
        n = s;
        n.req = '0;
        n.tmo = '0;
        if (!e) begin
            n.active = 0; n.pinging = 0; n.busy = 0;
            return n;
        end
        n.busy = 1;
        if (!s.active) begin
            n.active = 1; n.pinging = 0; n.left = int'(wc);
            return n;
        end
        if (!s.pinging) begin
            if (s.left > 0) begin
                n.left = s.left - 1;
            end else begin
                c = next_chan(s.last, ae);
                if (c < 0) begin
                    n.left = int'(wc);
                end else begin
                    n.pinging = 1; n.chan = c; n.last = c; n.age = 1; n.req = onehot(c);
                end
            end
            return n;
        end
        t = (tc == '0) ? 1 : int'(tc);
        if (!bit_of(ae, s.chan) || bit_of(ok, s.chan)) begin
            n.pinging = 0; n.left = int'(wc);
        end else if (s.age >= t) begin
            n.tmo = onehot(s.chan); n.pinging = 0; n.left = int'(wc);
        end else begin
            n.age = s.age + 1; n.req = onehot(s.chan);
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) m <= model_reset();
        else         m <= step(m, en, wait_cyc, timeout_cyc, alert_en, ping_if.ping_ok_i);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Observation of request runs and reactive receiver state.
    logic [N-1:0] prev_req = '0;
    int           run_len = 0, gap_cnt = 0, to_at_fall = 0;
    bit           seen_fall = 0;
    int           ch_q[$], len_q[$], gap_q[$];
    logic [N-1:0] to_q[$];
    int           resp_delay = -1, since_rise = -1, rise_ch = 0;
    bit           noise_en = 0;

    task automatic clear_obs();
        ch_q.delete(); len_q.delete(); gap_q.delete(); to_q.delete();
        seen_fall = 0; to_at_fall = 0; gap_cnt = 0; run_len = 0;
        prev_req = ping_if.ping_req_o;
    endtask

    task automatic cycle();
        logic [N-1:0] cur, tmo, okv;
        @(negedge clk);
        if (rst_ni) begin
            check("req", 32'(ping_if.ping_req_o), 32'(m.req));
            check("timeout", 32'(ping_if.ping_timeout_o), 32'(m.tmo));
            check("busy", 32'(busy), 32'(m.busy));
        end
        cur = ping_if.ping_req_o;
        tmo = ping_if.ping_timeout_o;
        if (cur != '0) begin
            if (prev_req == '0) begin
                ch_q.push_back(idx_of(cur));
                if (seen_fall) gap_q.push_back(gap_cnt);
                run_len = 0; since_rise = 0; rise_ch = idx_of(cur);
            end
            run_len++;
        end else begin
            if (prev_req != '0) begin
                len_q.push_back(run_len);
                seen_fall = 1; gap_cnt = 0;
                if (tmo != '0) to_at_fall++;
            end
            gap_cnt++;
        end
        if (tmo != '0) to_q.push_back(tmo);
        prev_req = cur;
        if (since_rise >= 0) since_rise++;
        okv = '0;
        if (resp_delay >= 0 && since_rise == resp_delay + 1) okv = onehot(rise_ch);
        if (noise_en && $urandom_range(0, 5) == 0) okv = okv | N'($urandom);
        ping_if.ping_ok_i = okv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0; en = 1'b0; ping_if.ping_ok_i = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        since_rise = -1;
        clear_obs();
        check("rst_req", 32'(ping_if.ping_req_o), 32'h0);
        check("rst_timeout", 32'(ping_if.ping_timeout_o), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
    endtask

    task automatic wait_req(input logic [N-1:0] pat, input int lim, input string nm);
        int k = 0;
        while (ping_if.ping_req_o !== pat && k < lim) begin cycle(); k++; end
        check(nm, 32'(ping_if.ping_req_o), 32'(pat));
    endtask

    task automatic wait_any(input int lim, output logic [N-1:0] got);
        int k = 0;
        while (ping_if.ping_req_o == '0 && k < lim) begin cycle(); k++; end
        got = ping_if.ping_req_o;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] got;
        ping_if.ping_ok_i = '0;

        // Rotation with responses two cycles after each request.
        do_reset();
        resp_delay = 2; wait_cyc = 3; timeout_cyc = 10; alert_en = 4'b1111; en = 1'b1;
        repeat (38) cycle();
        check("rot_count", 32'(ch_q.size()), 32'd5);
        if (ch_q.size() >= 5) for (int k = 0; k < 5; k++) check("rot_order", 32'(ch_q[k]), 32'(k % 4));
        if (len_q.size() >= 4) for (int k = 0; k < 4; k++) check("rot_len", 32'(len_q[k]), 32'd3);
        check("rot_gaps", 32'(gap_q.size()), 32'd4);
        if (gap_q.size() >= 4) for (int k = 0; k < 4; k++) check("rot_gap", 32'(gap_q[k]), 32'd4);
        check("rot_no_timeout", 32'(to_q.size()), 32'd0);

        // Timeout with no response on the only enabled channel.
        do_reset();
        resp_delay = -1; alert_en = 4'b0100; timeout_cyc = 5; en = 1'b1;
        repeat (16) cycle();
        check("to_chan", ch_q.size() > 0 ? 32'(ch_q[0]) : 32'hFFFF, 32'd2);
        check("to_len", len_q.size() > 0 ? 32'(len_q[0]) : 32'hFFFF, 32'd5);
        check("to_pulses", 32'(to_q.size()), 32'd1);
        check("to_value", to_q.size() > 0 ? 32'(to_q[0]) : 32'hFFFF, 32'h4);
        check("to_at_req_fall", 32'(to_at_fall), 32'd1);

        // Response in the last allowed request cycle.
        do_reset();
        resp_delay = 4; en = 1'b1;
        repeat (16) cycle();
        check("edge_ok_len", len_q.size() > 0 ? 32'(len_q[0]) : 32'hFFFF, 32'd5);
        check("edge_ok_no_to", 32'(to_q.size()), 32'd0);

        // Response one cycle too late.
        do_reset();
        resp_delay = 5; en = 1'b1;
        repeat (16) cycle();
        check("late_ok_len", len_q.size() > 0 ? 32'(len_q[0]) : 32'hFFFF, 32'd5);
        check("late_ok_to", to_q.size() > 0 ? 32'(to_q[0]) : 32'hFFFF, 32'h4);

        // Sparse enables, then none enabled.
        do_reset();
        resp_delay = 2; timeout_cyc = 10; alert_en = 4'b1001; en = 1'b1;
        repeat (31) cycle();
        check("sparse_count", 32'(ch_q.size()), 32'd4);
        if (ch_q.size() >= 4) for (int k = 0; k < 4; k++) check("sparse_order", 32'(ch_q[k]), (k % 2 == 0) ? 32'd0 : 32'd3);
        wait_req('0, 10, "sparse_quiet");
        alert_en = 4'b0000;
        clear_obs();
        repeat (20) cycle();
        check("none_no_req", 32'(ch_q.size()), 32'd0);
        check("none_busy", 32'(busy), 32'd1);

        // Scheduler disabled in the second cycle of a ping to channel 1.
        do_reset();
        alert_en = 4'b1111; resp_delay = 2; en = 1'b1;
        wait_req(4'b0010, 40, "dis_reach_ch1");
        cycle();
        en = 1'b0;
        cycle();
        check("dis_req", 32'(ping_if.ping_req_o), 32'h0);
        check("dis_timeout", 32'(ping_if.ping_timeout_o), 32'h0);
        check("dis_busy", 32'(busy), 32'h0);
        en = 1'b1;
        clear_obs();
        wait_any(30, got);
        check("dis_resume_ch2", 32'(got), 32'h4);

        // Asynchronous reset while channel 3 is being pinged.
        do_reset();
        alert_en = 4'b1111; resp_delay = 2; en = 1'b1;
        wait_req(4'b1000, 60, "rst_reach_ch3");
        #2 rst_ni = 1'b0;
        #1;
        check("arst_req", 32'(ping_if.ping_req_o), 32'h0);
        check("arst_timeout", 32'(ping_if.ping_timeout_o), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        since_rise = -1;
        clear_obs();
        wait_any(30, got);
        check("arst_first_ch0", 32'(got), 32'h1);

        // Randomized traffic against the model.
        do_reset();
        noise_en = 1'b1; en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (en && $urandom_range(0, 59) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
            if ($urandom_range(0, 39) == 0) alert_en = N'($urandom);
            if ($urandom_range(0, 99) == 0) wait_cyc = WW'($urandom_range(0, 4));
            if ($urandom_range(0, 99) == 0) timeout_cyc = TW'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0) resp_delay = int'($urandom_range(0, 7)) - 1;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
